// File: rtl/inst_sram_pkg.sv
// Shared constants for the RV64 instruction SRAM: word and address widths,
// default depth and the value rdata takes while reset is asserted.
package inst_sram_pkg;

    localparam int unsigned INST_W        = 32;
    localparam int unsigned XLEN          = 64;
    localparam int unsigned DEFAULT_DEPTH = 256;

    localparam logic [INST_W-1:0] RDATA_RST = 32'h0;

    // True when a 64-bit word index falls inside a memory of the given depth.
    function automatic logic idx_in_range(input logic [XLEN-1:0] idx,
                                          input int unsigned     depth);
        return idx < XLEN'(depth);
    endfunction

endpackage

// File: rtl/inst_sram_rv64_if.sv
// Bus bundle between the loader/IF stage (master) and the instruction SRAM (slave).
interface inst_sram_rv64_if;
    import inst_sram_pkg::*;

    logic              inst_sram_en;
    logic              inst_sram_wen;
    logic [XLEN-1:0]   inst_sram_addr;
    logic [XLEN-1:0]   inst_sram_waddr;
    logic [INST_W-1:0] inst_sram_wdata;
    logic [INST_W-1:0] inst_sram_rdata;

    modport master (
        output inst_sram_en, inst_sram_wen, inst_sram_addr,
               inst_sram_waddr, inst_sram_wdata,
        input  inst_sram_rdata
    );

    modport slave (
        input  inst_sram_en, inst_sram_wen, inst_sram_addr,
               inst_sram_waddr, inst_sram_wdata,
        output inst_sram_rdata
    );
endinterface

// File: rtl/inst_sram_array.sv
// Plain DEPTH x INST_W storage: synchronous write, combinational read index.
// Contents are never cleared; unwritten words read back as X in simulation.
module inst_sram_array
    import inst_sram_pkg::*;
#(
    parameter int unsigned DEPTH  = DEFAULT_DEPTH,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [INST_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [INST_W-1:0] o_rdata
);

    logic [INST_W-1:0] r_mem [DEPTH];

    // Store the incoming word when the top level has qualified the write.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/inst_sram_rv64.sv
// RV64 instruction SRAM top: range checks, write gating, one-cycle registered
// read with asynchronous active-low clear of rdata.
// Optional macro INST_SRAM_BYPASS_EN: a same-cycle read and write to the same
// valid index returns the new write data (write-first) instead of the old word.
module inst_sram_rv64
    import inst_sram_pkg::*;
#(
    parameter int unsigned DEPTH  = DEFAULT_DEPTH,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    inst_sram_rv64_if.slave  bus
);

    logic              w_raddr_ok;
    logic              w_waddr_ok;
    logic              w_we;
    logic [INST_W-1:0] w_mem_rdata;
    logic [INST_W-1:0] w_rd_word;
    logic [INST_W-1:0] r_rdata;

    assign w_raddr_ok = idx_in_range(bus.inst_sram_addr, DEPTH);
    assign w_waddr_ok = idx_in_range(bus.inst_sram_waddr, DEPTH);

    // Out-of-range writes are dropped (no aliasing) and reset blocks writes.
    assign w_we = bus.inst_sram_wen && w_waddr_ok && rst_n;

    inst_sram_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (bus.inst_sram_waddr[ADDR_W-1:0]),
        .i_wdata (bus.inst_sram_wdata),
        .i_raddr (bus.inst_sram_addr[ADDR_W-1:0]),
        .o_rdata (w_mem_rdata)
    );

    // Select the word to capture: zero for out-of-range reads, optional forwarding.
    always_comb begin
        w_rd_word = RDATA_RST;
        if (w_raddr_ok) begin
            w_rd_word = w_mem_rdata;
`ifdef INST_SRAM_BYPASS_EN
            if (w_we && (bus.inst_sram_waddr == bus.inst_sram_addr)) begin
                w_rd_word = bus.inst_sram_wdata;
            end
`endif
        end
    end

    // Read data register: cleared at once by reset, updated only when enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= RDATA_RST;
        end else if (bus.inst_sram_en) begin
            r_rdata <= w_rd_word;
        end
    end

    assign bus.inst_sram_rdata = r_rdata;

endmodule

// File: tb/tb_inst_sram_rv64.sv
// Directed self-checking bench for inst_sram_rv64 (default depth 256).
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
module tb_inst_sram_rv64;
    import inst_sram_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    inst_sram_rv64_if bus ();

    inst_sram_rv64 #(.DEPTH(256), .ADDR_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("check %-16s rdata=%08h ok", tag, got);
        end else begin
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic wen, input logic [63:0] addr,
                         input logic [63:0] waddr, input logic [31:0] wdata);
        bus.inst_sram_en    = en;
        bus.inst_sram_wen   = wen;
        bus.inst_sram_addr  = addr;
        bus.inst_sram_waddr = waddr;
        bus.inst_sram_wdata = wdata;
    endtask

    logic [63:0] pre_addr [4] = '{64'd1, 64'd2, 64'd3, 64'd4};
    logic [31:0] pre_data [4] = '{32'h01400113, 32'h00510193, 32'h00100A13, 32'h003A30A3};
    logic [31:0] same_exp;

    initial begin
        n_checks = 0;
        n_pass   = 0;
`ifdef INST_SRAM_BYPASS_EN
        same_exp = 32'hDEADBEEF;
`else
        same_exp = 32'h00100A13;
`endif
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 64'd0, 64'd0, 32'h0);
        #3;
        check("reset_state", bus.inst_sram_rdata, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;

        // Preload with en=0; rdata must stay at its reset value throughout.
        drive(1'b0, 1'b1, 64'd0, 64'd0, 32'hCAFE0000);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 64'd0, pre_addr[i], pre_data[i]);
            tick();
        end
        check("wen_no_en_hold", bus.inst_sram_rdata, 32'h0);

        // Sequential reads, one cycle latency each.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, pre_addr[i], 64'd0, 32'h0);
            tick();
            check($sformatf("read_addr%0d", i + 1), bus.inst_sram_rdata, pre_data[i]);
        end

        // Asynchronous reset in the middle of a read cycle.
        drive(1'b1, 1'b0, 64'd3, 64'd0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", bus.inst_sram_rdata, 32'h0);
        // A write attempted during reset must be blocked.
        drive(1'b1, 1'b1, 64'd3, 64'd1, 32'h00000BAD);
        tick();
        check("reset_holds_zero", bus.inst_sram_rdata, 32'h0);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 64'd2, 64'd0, 32'h0);
        tick();
        check("retained_addr2", bus.inst_sram_rdata, 32'h00510193);
        drive(1'b1, 1'b0, 64'd1, 64'd0, 32'h0);
        tick();
        check("reset_blocks_wr", bus.inst_sram_rdata, 32'h01400113);

        // en=0 with a changing address holds the last value.
        drive(1'b0, 1'b0, 64'd4, 64'd0, 32'h0);
        tick();
        check("hold_en0_a", bus.inst_sram_rdata, 32'h01400113);
        drive(1'b0, 1'b0, 64'd2, 64'd0, 32'h0);
        tick();
        check("hold_en0_b", bus.inst_sram_rdata, 32'h01400113);

        // Same-address read and write.
        drive(1'b1, 1'b1, 64'd3, 64'd3, 32'hDEADBEEF);
        tick();
        check("same_addr_rw", bus.inst_sram_rdata, same_exp);
        drive(1'b1, 1'b0, 64'd3, 64'd0, 32'h0);
        tick();
        check("same_addr_after", bus.inst_sram_rdata, 32'hDEADBEEF);

        // Different-address read and write in one cycle.
        drive(1'b1, 1'b1, 64'd2, 64'd5, 32'h11112222);
        tick();
        check("diff_addr_rd", bus.inst_sram_rdata, 32'h00510193);
        drive(1'b1, 1'b0, 64'd5, 64'd0, 32'h0);
        tick();
        check("diff_addr_wr", bus.inst_sram_rdata, 32'h11112222);

        // Out-of-range writes: waddr=DEPTH and a large index whose low bits are 0.
        drive(1'b0, 1'b1, 64'd0, 64'd256, 32'h12345678);
        tick();
        drive(1'b0, 1'b1, 64'd0, 64'h0000_0001_0000_0000, 32'h87654321);
        tick();
        drive(1'b1, 1'b0, 64'd0, 64'd0, 32'h0);
        tick();
        check("oor_write_addr0", bus.inst_sram_rdata, 32'hCAFE0000);

        // Top valid index.
        drive(1'b0, 1'b1, 64'd0, 64'd255, 32'hA5A5F00D);
        tick();
        drive(1'b1, 1'b0, 64'd255, 64'd0, 32'h0);
        tick();
        check("top_index_255", bus.inst_sram_rdata, 32'hA5A5F00D);

        // Out-of-range reads return zero.
        drive(1'b1, 1'b0, 64'd300, 64'd0, 32'h0);
        tick();
        check("oor_read_300", bus.inst_sram_rdata, 32'h0);
        drive(1'b1, 1'b0, 64'd1, 64'd0, 32'h0);
        tick();
        drive(1'b1, 1'b0, 64'd256, 64'd0, 32'h0);
        tick();
        check("oor_read_256", bus.inst_sram_rdata, 32'h0);
        drive(1'b1, 1'b0, 64'h8000_0000_0000_0004, 64'd0, 32'h0);
        tick();
        check("oor_read_high", bus.inst_sram_rdata, 32'h0);

        drive(1'b0, 1'b0, 64'd0, 64'd0, 32'h0);
        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
